// File: rtl/pc_seq_if.sv
// pc_seq_if: fetch-control bundle between the PC sequencer and its driver.
// The slave modport is the sequencer; the master modport is the fetch
// controller that issues stall/trap/branch/call/ret and consumes pc/ce.
interface pc_seq_if #(
  parameter int unsigned AW = 72
);
  logic          stall;
  logic          trap;
  logic          branch;
  logic          call;
  logic          ret;
  logic [AW-1:0] tgt;
  logic          ce;
  logic [AW-1:0] pc;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_uflow;

  modport master (
    output stall, trap, branch, call, ret, tgt,
    input  ce, pc, ras_empty, ras_full, ras_uflow
  );

  modport slave (
    input  stall, trap, branch, call, ret, tgt,
    output ce, pc, ras_empty, ras_full, ras_uflow
  );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: parametrised program-counter sequencer for the fetch stage.
// Next-PC priority: trap > stall > call&ret > ret > call > branch > sequential.
// Optional feature macro: PC_RAS_EN adds a circular call/return address stack.
// Without it, call and ret act as plain branches and the RAS flags are tied off.
module pc_seq_unit #(
  parameter int unsigned   AW        = 72,
  parameter int unsigned   STEP      = 9,
  parameter logic [AW-1:0] RESET_VEC = 72'h0,
  parameter logic [AW-1:0] TRAP_VEC  = 72'h100,
  parameter int unsigned   RAS_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  pc_seq_if.slave bus
);

  logic [AW-1:0] pc_r;
  logic [AW-1:0] pc_nxt_s;
  logic [AW-1:0] pc_inc_s;
  logic          ce_r;
  logic          uflow_r;
  logic          uflow_nxt_s;

  // Sequential address wraps silently modulo 2^AW.
  assign pc_inc_s = pc_r + AW'(STEP);

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] ras_r [RAS_DEPTH];
  logic [PW-1:0] top_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          empty_r;
  logic          full_r;
  logic          push_s;
  logic          pop_s;
  logic          over_s;

  // Select the next PC and the stack action implied by the control inputs.
  always_comb begin
    pc_nxt_s    = pc_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    over_s      = 1'b0;
    uflow_nxt_s = 1'b0;
    if (!ce_r) begin
      pc_nxt_s = pc_r;
    end else if (bus.trap) begin
      pc_nxt_s = TRAP_VEC;
    end else if (bus.stall) begin
      pc_nxt_s = pc_r;
    end else if (bus.call && bus.ret && (cnt_r != CW'(0))) begin
      // Return and immediately re-enter: reuse the top slot in place.
      pc_nxt_s = ras_r[top_r];
      over_s   = 1'b1;
    end else if (bus.ret && !bus.call) begin
      if (cnt_r != CW'(0)) begin
        pc_nxt_s = ras_r[top_r];
        pop_s    = 1'b1;
      end else begin
        pc_nxt_s    = bus.tgt;
        uflow_nxt_s = 1'b1;
      end
    end else if (bus.call) begin
      // Also covers call&ret on an empty stack.
      pc_nxt_s = bus.tgt;
      push_s   = 1'b1;
    end else if (bus.branch) begin
      pc_nxt_s = bus.tgt;
    end else begin
      pc_nxt_s = pc_inc_s;
    end
  end

  // Next entry count; a push while full overwrites the oldest entry.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (cnt_r != CW'(RAS_DEPTH)) begin
          cnt_nxt_s = cnt_r + CW'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Stack pointer, count and registered occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_r   <= '0;
      cnt_r   <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      empty_r <= (cnt_nxt_s == CW'(0));
      full_r  <= (cnt_nxt_s == CW'(RAS_DEPTH));
      if (push_s) begin
        top_r <= top_r + PW'(1);
      end else if (pop_s) begin
        top_r <= top_r - PW'(1);
      end else begin
        top_r <= top_r;
      end
    end
  end

  // Stack storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_r[top_r + PW'(1)] <= pc_inc_s;
    end else if (over_s) begin
      ras_r[top_r] <= pc_inc_s;
    end
  end

  assign bus.ras_empty = empty_r;
  assign bus.ras_full  = full_r;
`else
  // Select the next PC; call and ret degrade to plain branches.
  always_comb begin
    pc_nxt_s    = pc_r;
    uflow_nxt_s = 1'b0;
    if (!ce_r) begin
      pc_nxt_s = pc_r;
    end else if (bus.trap) begin
      pc_nxt_s = TRAP_VEC;
    end else if (bus.stall) begin
      pc_nxt_s = pc_r;
    end else if (bus.branch || bus.call || bus.ret) begin
      pc_nxt_s = bus.tgt;
    end else begin
      pc_nxt_s = pc_inc_s;
    end
  end

  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
`endif

  // PC, fetch enable and underflow pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_r    <= 1'b0;
      pc_r    <= RESET_VEC;
      uflow_r <= 1'b0;
    end else begin
      ce_r    <= 1'b1;
      pc_r    <= pc_nxt_s;
      uflow_r <= uflow_nxt_s;
    end
  end

  assign bus.ce        = ce_r;
  assign bus.pc        = pc_r;
  assign bus.ras_uflow = uflow_r;

endmodule
